// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: default geometry,
// statistics counter width and the wrapping pointer increment.
package ram_fifo_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 8;
    localparam int STALL_CNT_W = 16;

    // Next pointer value for a ring of 'depth' entries (wraps depth-1 -> 0).
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM pointer: advances by one on 'adv', wraps at DEPTH-1 so a
// non-power-of-two RAM depth is handled correctly.
module ram_fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_nxt;

    // Wrapped increment of the current pointer.
    always_comb begin
        ptr_nxt = AW'(ptr_next(32'(ptr), DEPTH));
    end

    // Pointer register, moves only when the owning side is granted the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous RAM. Reads win the
// RAM port; a read blocks the following read (in-flight flag), so a write
// slot is always available on the next cycle.
// Optional build macro: RAM_FIFO_CTRL_STATS_EN enables the write-stall counter;
// without it stall_cnt is constant zero.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int  WIDTH         = DEF_WIDTH,
    parameter int  DEPTH         = DEF_DEPTH,
    localparam int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [WIDTH-1:0]         s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [WIDTH-1:0]         m_data,
    input  logic                     m_ready,
    output logic                     ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]         ram_wdata,
    input  logic [WIDTH-1:0]         ram_rdata,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);

    localparam logic [ADDRESS_WIDTH:0] FULL_CNT = (ADDRESS_WIDTH+1)'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [ADDRESS_WIDTH:0]   count;
    logic                     rd_inflight;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     not_full;
    logic                     rd_go;
    logic                     wr_go;

    // Port arbitration: a read is issued only when its result has somewhere to
    // land next cycle; m_ready reaches s_ready combinationally through rd_go.
    assign not_full  = (count != FULL_CNT);
    assign rd_go     = (count != '0) && !rd_inflight && (!out_valid || m_ready);
    assign wr_go     = s_valid && not_full && !rd_go;
    assign s_ready   = not_full && !rd_go;

    assign ram_wr_en = wr_go;
    assign ram_addr  = rd_go ? rd_ptr : wr_ptr;
    assign ram_wdata = s_data;

    assign m_valid   = out_valid;
    assign m_data    = out_data;
    assign level     = count + {{ADDRESS_WIDTH{1'b0}}, rd_inflight}
                             + {{ADDRESS_WIDTH{1'b0}}, out_valid};

    ram_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (wr_go),
        .ptr   (wr_ptr)
    );

    ram_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (rd_go),
        .ptr   (rd_ptr)
    );

    // Words resident in the RAM; the port is exclusive so only one direction per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (rd_go) begin
            count <= count - 1'b1;
        end else if (wr_go) begin
            count <= count + 1'b1;
        end
    end

    // Read pipeline: in-flight flag, then capture of the RAM's registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            rd_inflight <= rd_go;
            if (rd_inflight) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
            end else if (out_valid && m_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RAM_FIFO_CTRL_STATS_EN
    // Saturating count of cycles where the producer was held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (s_valid && !s_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural single-port RAM and a
// queue-based FIFO reference model checked every cycle.
module tb_ram_fifo_ctrl;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata;
    logic [AW:0]   level;
    logic [15:0]   stall_cnt;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] q[$];
    int           model_stall = 0;
    logic [W-1:0] mem [D];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    // Single-port synchronous RAM with registered read data.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Per-cycle scoreboard, called at the falling edge before the next rising edge.
    task automatic mon();
        int exp_stall;
        logic [W-1:0] exp;
`ifdef RAM_FIFO_CTRL_STATS_EN
        exp_stall = model_stall;
`else
        exp_stall = 0;
`endif
        vectors++;
        if ($isunknown(level) || int'(level) != q.size()) begin
            miscompares++;
            $display("FAIL level: got %0d, model holds %0d", level, q.size());
        end
        vectors++;
        if (ram_wr_en !== (s_valid && s_ready)) begin
            miscompares++;
            $display("FAIL ram_wr_en: got %b, accepted write %b", ram_wr_en, s_valid && s_ready);
        end
        if (q.size() == 0) begin
            vectors++;
            if (m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL m_valid_empty: got %b, expected 0", m_valid);
            end
        end
        vectors++;
        if (int'(stall_cnt) != exp_stall) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d, expected %0d", stall_cnt, exp_stall);
        end
        if (m_valid && m_ready) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_empty: got word %h, expected none", m_data);
            end else begin
                exp = q.pop_front();
                if (m_data !== exp) begin
                    miscompares++;
                    $display("FAIL order: got %h, expected %h", m_data, exp);
                end
            end
        end
        if (s_valid && s_ready) q.push_back(s_data);
        if (s_valid && !s_ready && model_stall < 65535) model_stall++;
    endtask

    task automatic adv();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        q.delete();
        model_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Offer one word until accepted; polite mode raises s_valid only when s_ready.
    task automatic push(input logic [W-1:0] d, input bit polite);
        bit ok = 0;
        s_data = d;
        for (int n = 0; n < 60 && !ok; n++) begin
            s_valid = polite ? s_ready : 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) ok = 1;
            adv();
        end
        s_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: word %h not accepted, expected acceptance", d);
        end
    endtask

    task automatic drain();
        int n = 0;
        m_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            adv();
            n++;
        end
        @(negedge clk);
        adv();
        m_ready = 1'b0;
        vectors++;
        if (q.size() != 0 || level !== '0) begin
            miscompares++;
            $display("FAIL drain: level %0d model %0d, expected 0", level, q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1 || level !== '0 || ram_wr_en !== 1'b0 ||
                stall_cnt !== '0 || ram_addr !== '0 || m_data !== '0) begin
                miscompares++;
                $display("FAIL reset_idle: mv=%b sr=%b lvl=%0d we=%b st=%0d addr=%0d md=%h, expected 0 1 0 0 0 0 00",
                         m_valid, s_ready, level, ram_wr_en, stall_cnt, ram_addr, m_data);
            end
            adv();
        end
    endtask

    task automatic test_single();
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        @(negedge clk);
        vectors++;
        if (ram_wr_en !== 1'b1 || ram_addr !== '0) begin
            miscompares++;
            $display("FAIL single_write: we=%b addr=%0d, expected 1 0", ram_wr_en, ram_addr);
        end
        adv();
        s_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (ram_wr_en !== 1'b0 || ram_addr !== '0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_read: we=%b addr=%0d mv=%b, expected 0 0 0", ram_wr_en, ram_addr, m_valid);
        end
        adv();
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_n2: m_valid %b, expected 0", m_valid);
        end
        adv();
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_n3: mv=%b md=%h, expected 1 a5", m_valid, m_data);
        end
        adv();
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0 || level !== '0) begin
            miscompares++;
            $display("FAIL single_after: mv=%b lvl=%0d, expected 0 0", m_valid, level);
        end
        adv();
        m_ready = 1'b0;
    endtask

    task automatic test_fill();
        logic [W-1:0] exp = 8'h01;
        do_reset();
        for (int i = 1; i <= D + 1; i++) push(W'(i), 1'b0);
        @(negedge clk);
        vectors++;
        if (level !== AW'(0) + (AW+1)'(D + 1) || s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h01) begin
            miscompares++;
            $display("FAIL fill_full: lvl=%0d sr=%b mv=%b md=%h, expected %0d 0 1 01", level, s_ready, m_valid, m_data, D + 1);
        end
        adv();
        s_valid = 1'b1;
        s_data  = 8'h0A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_stall: s_ready %b, expected 0", s_ready);
            end
            adv();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int n = 0; n < 100 && exp <= 8'h09; n++) begin
            @(negedge clk);
            if (m_valid) begin
                vectors++;
                if (m_data !== exp) begin
                    miscompares++;
                    $display("FAIL fill_drain: got %h, expected %h", m_data, exp);
                end
                exp++;
            end
            adv();
        end
        if (exp <= 8'h09) begin
            vectors++;
            miscompares++;
            $display("FAIL fill_drain_timeout: next word %h never seen, expected up to 09", exp);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int  writes = 0;
        int  wraps = 0;
        int  b2b = 0;
        bit  prev_wr = 0;
        bit  acc;
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = W'($urandom);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            if (ram_wr_en) writes++;
            if (ram_wr_en && ram_addr == AW'(D - 1)) wraps++;
            if (ram_wr_en && prev_wr) b2b++;
            prev_wr = ram_wr_en;
            adv();
            if (acc) s_data = W'($urandom);
        end
        s_valid = 1'b0;
        vectors++;
        if (writes < 18 || wraps < 2 || b2b != 0) begin
            miscompares++;
            $display("FAIL b2b_rate: writes=%0d wraps=%0d consecutive=%0d, expected >=18 >=2 0", writes, wraps, b2b);
        end
        drain();
    endtask

    task automatic test_hold();
        logic [W-1:0] w [3];
        bit got = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w[i] = W'($urandom);
            push(w[i], 1'b0);
        end
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (m_valid) got = 1;
            else adv();
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL hold_wait: m_valid 0, expected 1");
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if (m_valid !== 1'b1 || m_data !== w[0]) begin
                miscompares++;
                $display("FAIL hold_stable: mv=%b md=%h, expected 1 %h", m_valid, m_data, w[0]);
            end
            adv();
        end
        m_ready = 1'b1;
        @(negedge clk);
        adv();
        m_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_pop1: m_valid %b, expected 0", m_valid);
        end
        adv();
        @(negedge clk);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== w[1]) begin
            miscompares++;
            $display("FAIL hold_pop2: mv=%b md=%h, expected 1 %h", m_valid, m_data, w[1]);
        end
        adv();
        drain();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            s_data  = W'($urandom);
            @(negedge clk);
            adv();
        end
        s_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) push(W'($urandom), 1'b0);
        m_ready = 1'b1;
        @(negedge clk);
        adv();
        m_ready = 1'b0;
        vectors++;
        if (level !== (AW+1)'(5)) begin
            miscompares++;
            $display("FAIL mid_level: got %0d, expected 5", level);
        end
        rst_n = 1'b0;
        q.delete();
        model_stall = 0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || level !== '0 || ram_wr_en !== 1'b0 || ram_addr !== '0 ||
            s_ready !== 1'b1 || m_data !== '0 || stall_cnt !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: mv=%b lvl=%0d we=%b addr=%0d sr=%b md=%h st=%0d, expected 0 0 0 0 1 00 0",
                     m_valid, level, ram_wr_en, ram_addr, s_ready, m_data, stall_cnt);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (m_valid !== 1'b0 || level !== '0) begin
                miscompares++;
                $display("FAIL mid_after: mv=%b lvl=%0d, expected 0 0", m_valid, level);
            end
            adv();
        end
    endtask

    task automatic test_stats();
        int exp;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < D + 1; i++) push(W'($urandom), 1'b1);
        s_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            adv();
        end
        s_valid = 1'b0;
`ifdef RAM_FIFO_CTRL_STATS_EN
        exp = 12;
`else
        exp = 0;
`endif
        @(negedge clk);
        vectors++;
        if (int'(stall_cnt) != exp) begin
            miscompares++;
            $display("FAIL stats_12: got %0d, expected %0d", stall_cnt, exp);
        end
        adv();
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_hold();
        test_random();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
